// File: rtl/midi_key_bitmap.sv
// MIDI byte-stream parser with running status, tracking held notes as a 128-bit
// vector plus a registered popcount and a one-cycle change strobe.
module midi_key_bitmap #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic         clk50M,
  input  logic         rst,
  input  logic [7:0]   midi_byte,
  input  logic         midi_valid,
  output logic [127:0] keys,
  output logic [7:0]   key_count,
  output logic         changed
);

  typedef enum logic [1:0] {StIdle, StD1, StD2} state_e;

  state_e       state_q, state_d;
  logic [7:0]   status_q, status_d;
  logic [6:0]   d1_q, d1_d;
  logic [127:0] keys_q, keys_d;
  logic [7:0]   count_q, count_d;
  logic         changed_q, changed_d;

  logic         msg_done;
  logic         chan_ok;
  logic         note_on, note_off, all_off;
  logic [6:0]   vel;

  assign vel     = midi_byte[6:0];
  assign chan_ok = OMNI || (status_q[3:0] == CHANNEL);

  // Parser: real-time bytes (F8-FF) fall through every branch untouched.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    if (midi_valid) begin
      if (midi_byte[7]) begin
        if (midi_byte[7:4] != 4'hF) begin
          status_d = midi_byte;
          state_d  = StD1;
        end else if (!midi_byte[3]) begin
          status_d = 8'h00;
          state_d  = StIdle;
        end
      end else begin
        case (state_q)
          StIdle: state_d = StIdle;
          StD1: begin
            // Program change / channel pressure are single-data-byte messages.
            if (status_q[7:5] != 3'b110) begin
              d1_d    = midi_byte[6:0];
              state_d = StD2;
            end
          end
          StD2: begin
            msg_done = 1'b1;
            state_d  = StD1;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    note_on  = msg_done && chan_ok && (status_q[7:4] == 4'h9) && (vel != 7'd0);
    note_off = msg_done && chan_ok && ((status_q[7:4] == 4'h8) ||
               ((status_q[7:4] == 4'h9) && (vel == 7'd0)));
    all_off  = msg_done && chan_ok && (status_q[7:4] == 4'hB) &&
               ((d1_q == 7'd120) || (d1_q == 7'd123));
  end

  always_comb begin
    keys_d    = keys_q;
    count_d   = count_q;
    changed_d = 1'b0;
    if (note_on && !keys_q[d1_q]) begin
      keys_d[d1_q] = 1'b1;
      count_d      = count_q + 8'd1;
      changed_d    = 1'b1;
    end else if (note_off && keys_q[d1_q]) begin
      keys_d[d1_q] = 1'b0;
      count_d      = count_q - 8'd1;
      changed_d    = 1'b1;
    end else if (all_off && (keys_q != '0)) begin
      keys_d    = '0;
      count_d   = 8'd0;
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q   <= StIdle;
      status_q  <= 8'h00;
      d1_q      <= 7'd0;
      keys_q    <= '0;
      count_q   <= 8'd0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      d1_q      <= d1_d;
      keys_q    <= keys_d;
      count_q   <= count_d;
      changed_q <= changed_d;
    end
  end

  assign keys      = keys_q;
  assign key_count = count_q;
  assign changed   = changed_q;

endmodule
